// File: rtl/lsu_data_mem.sv
// lsu_data_mem: request/response data memory for the LSU path.
// Byte/half/word accesses with byte-lane writes, sign/zero-extended loads,
// misalignment detection and a hardware clear sequencer (INIT -> RUN).
// Optional feature macro: LSU_DATA_MEM_MISALIGN_TRAP_EN
//   defined   : misaligned accesses are suppressed and flagged
//   undefined : misaligned addresses are aligned down and the access proceeds
module lsu_data_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_clear,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rdata,
    output logic             misalign_err
);

    localparam int unsigned NL = WIDTH / 8;       // byte lanes per word
    localparam int unsigned LW = $clog2(NL);      // lane offset bits
    localparam int unsigned IW = $clog2(DEPTH);   // word index bits

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [IW-1:0]    cnt_q;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             rsp_valid_q;
    logic [WIDTH-1:0] rdata_q;
    logic             err_q;

    logic             accept;
    logic [LW-1:0]    lane_raw;
    logic [LW-1:0]    lane;
    logic [LW-1:0]    mask;
    logic [IW-1:0]    word_idx;
    int unsigned      nbytes;
    logic             illegal;
    logic             suppress;
`ifdef LSU_DATA_MEM_MISALIGN_TRAP_EN
    logic             misaligned;
`endif

    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] wr_merged;
    logic [31:0]      ld_raw;
    logic             ld_sign;
    logic [WIDTH-1:0] ext_mask;
    logic [WIDTH-1:0] ld_ext;
    logic [WIDTH-1:0] rdata_d;
    int unsigned      pos;

    logic             mem_we;
    logic [IW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    assign req_ready = (state_q == ST_RUN) && !mem_clear;
    assign accept    = req_valid && req_ready;

    assign lane_raw  = addr[LW-1:0];
    assign word_idx  = addr[LW +: IW];

    // Upper address bits wrap the space and are intentionally ignored
    if (LW + IW < 32) begin : g_unused_addr
        logic unused_addr;
        assign unused_addr = ^addr[31:LW+IW];
    end

    // Only the low 32 bits of store data are ever written
    if (WIDTH > 32) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^wdata[WIDTH-1:32];
    end

    // Access size decode, misalignment check and effective lane offset
    always_comb begin
        nbytes  = 4;
        mask    = '0;
        case (req_size)
            2'd0:    nbytes = 1;
            2'd1:    begin nbytes = 2; mask = LW'(1); end
            default: begin nbytes = 4; mask = LW'(3); end
        endcase
        illegal = (req_size == 2'd3);
`ifdef LSU_DATA_MEM_MISALIGN_TRAP_EN
        misaligned = ((lane_raw & mask) != '0)
                   || ((req_size == 2'd2) && (lane_raw > LW'(NL - 4)));
        suppress   = illegal || misaligned;
        lane       = lane_raw;
`else
        suppress   = illegal;
        lane       = lane_raw & ~mask;
`endif
    end

    // Lane gather for loads and lane merge for stores on the addressed word
    always_comb begin
        rd_word   = mem_q[word_idx];
        wr_merged = rd_word;
        ld_raw    = '0;
        pos       = 0;
        for (int unsigned k = 0; k < 4; k++) begin
            pos = 32'(lane) + k;
            if ((k < nbytes) && (pos < NL)) begin
                wr_merged[8*pos +: 8] = wdata[8*k +: 8];
                ld_raw[8*k +: 8]      = rd_word[8*pos +: 8];
            end
        end
        case (req_size)
            2'd0: begin
                ld_sign  = ld_raw[7];
                ext_mask = ~WIDTH'(32'h0000_00FF);
            end
            2'd1: begin
                ld_sign  = ld_raw[15];
                ext_mask = ~WIDTH'(32'h0000_FFFF);
            end
            default: begin
                ld_sign  = ld_raw[31];
                ext_mask = ~WIDTH'(32'hFFFF_FFFF);
            end
        endcase
        ld_ext  = WIDTH'(ld_raw) | ((ld_sign && !req_unsigned) ? ext_mask : '0);
        rdata_d = (req_write || suppress) ? '0 : ld_ext;
    end

    // Array write port: clear sequencer owns it in INIT, stores in RUN
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = word_idx;
        mem_wdata = wr_merged;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (accept && req_write && !suppress) begin
            mem_we    = 1'b1;
        end
    end

    // Memory array (no reset; zeroed by the clear sequencer)
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Clear sequencer FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (mem_clear) begin
                        cnt_q <= '0;
                    end else if (cnt_q == IW'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + IW'(1);
                    end
                end
                default: begin
                    if (mem_clear) begin
                        state_q <= ST_INIT;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    // Response registers; data and error hold between responses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rdata_q <= rdata_d;
                err_q   <= suppress;
            end
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rdata        = rdata_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Self-checking bench for lsu_data_mem against a byte-addressed reference model.
module tb_lsu_data_mem;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MEMB  = DEPTH * WIDTH / 8;

    logic             clk;
    logic             reset_n;
    logic             mem_clear;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [31:0]      addr;
    logic [WIDTH-1:0] wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rdata;
    logic             misalign_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mref [MEMB];
    int unsigned init_left;
    logic [31:0] last_rd;
    logic        last_err;
    logic [31:0] got;

`ifdef LSU_DATA_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    lsu_data_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_clear    (mem_clear),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .rsp_valid    (rsp_valid),
        .rdata        (rdata),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic void clear_model();
        for (int i = 0; i < int'(MEMB); i++) mref[i] = 8'h00;
    endfunction

    // Reference behaviour of one accepted request on a flat byte memory
    function automatic void model_req(input logic w, input logic [1:0] sz, input logic u,
                                      input logic [31:0] a, input logic [31:0] d,
                                      output logic [31:0] rd, output logic err);
        int unsigned base;
        int unsigned nb;
        logic [63:0] v;
        rd   = '0;
        err  = 1'b0;
        v    = '0;
        base = a % MEMB;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3) begin
            err = 1'b1;
            return;
        end
        if (TRAP && (base % nb != 0)) begin
            err = 1'b1;
            return;
        end
        base = base - (base % nb);
        if (w) begin
            for (int unsigned k = 0; k < nb; k++) mref[base + k] = d[8*k +: 8];
        end else begin
            for (int unsigned k = 0; k < nb; k++) v = v | (64'(mref[base + k]) << (8 * k));
            if (!u && v[8*nb - 1]) v = v | (~64'(0) << (8 * nb));
            rd = v[31:0];
        end
    endfunction

    // One clock cycle: drive at negedge, check ready, check response after the edge
    task automatic step(input logic v, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input logic clr,
                        output logic [31:0] obs);
        logic        acc;
        logic        rdy_exp;
        logic [31:0] erd;
        logic        eerr;
        req_valid    = v;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        addr         = a;
        wdata        = d;
        mem_clear    = clr;
        #1;
        rdy_exp = (init_left == 0) && !clr;
        check_eq("req_ready", 32'(req_ready), 32'(rdy_exp));
        acc  = v && rdy_exp;
        erd  = '0;
        eerr = 1'b0;
        if (acc) model_req(w, sz, u, a, d, erd, eerr);
        if (clr) begin
            init_left = DEPTH;
            clear_model();
        end else if (init_left > 0) begin
            init_left--;
        end
        @(posedge clk);
        #1;
        check_eq("rsp_valid", 32'(rsp_valid), 32'(acc));
        if (acc) begin
            last_rd  = erd;
            last_err = eerr;
        end
        check_eq("rdata", rdata, last_rd);
        check_eq("misalign_err", 32'(misalign_err), 32'(last_err));
        obs = rdata;
        @(negedge clk);
    endtask

    task automatic idle(input logic clr);
        logic [31:0] o;
        step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, clr, o);
    endtask

    task automatic ld(input logic [1:0] sz, input logic u, input logic [31:0] a, output logic [31:0] o);
        step(1'b1, 1'b0, sz, u, a, 32'h0, 1'b0, o);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] o;
        step(1'b1, 1'b1, sz, 1'b0, a, d, 1'b0, o);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        init_left = DEPTH;
        last_rd   = '0;
        last_err  = 1'b0;
        clear_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] sb [4];
        logic [31:0] ub [4];
        logic        r_v, r_w, r_u, r_c;
        logic [1:0]  r_sz;
        int unsigned r;
        sb[0] = 32'hFFFF_FFEF; sb[1] = 32'hFFFF_FFBE; sb[2] = 32'hFFFF_FFAD; sb[3] = 32'hFFFF_FFDE;
        ub[0] = 32'h0000_00EF; ub[1] = 32'h0000_00BE; ub[2] = 32'h0000_00AD; ub[3] = 32'h0000_00DE;

        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        addr = '0; wdata = '0; mem_clear = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_err", 32'(misalign_err), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        reset_n = 1'b1;

        // Clear sequencer: DEPTH cycles not ready, then every word reads zero
        repeat (DEPTH) idle(1'b0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            ld(2'd2, 1'b0, 32'(i * 4), got);
            check_eq("init_zero", got, 32'h0);
        end

        // Byte loads of a stored word, signed and unsigned
        st(2'd2, 32'h40, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            ld(2'd0, 1'b0, 32'(32'h40 + i), got);
            check_eq("lb_signed", got, sb[i]);
        end
        for (int i = 0; i < 4; i++) begin
            ld(2'd0, 1'b1, 32'(32'h40 + i), got);
            check_eq("lb_unsigned", got, ub[i]);
        end

        // Half store merges into upper lanes
        st(2'd2, 32'h40, 32'h1122_3344);
        st(2'd1, 32'h42, 32'h0000_8001);
        ld(2'd2, 1'b0, 32'h40, got);
        check_eq("half_merge", got, 32'h8001_3344);
        ld(2'd1, 1'b0, 32'h42, got);
        check_eq("lh_signed", got, 32'hFFFF_8001);
        ld(2'd1, 1'b1, 32'h42, got);
        check_eq("lh_unsigned", got, 32'h0000_8001);

        // Misaligned word store
        st(2'd2, 32'h40, 32'h0);
        st(2'd2, 32'h41, 32'hCAFE_F00D);
        check_eq("mis_word_err", 32'(misalign_err), 32'(TRAP));
        ld(2'd2, 1'b0, 32'h40, got);
        check_eq("mis_word_mem", got, TRAP ? 32'h0 : 32'hCAFE_F00D);
        ld(2'd1, 1'b0, 32'h43, got);
        check_eq("mis_half_err", 32'(misalign_err), 32'(TRAP));

        // Back-to-back loads, mem_clear on the third
        st(2'd2, 32'h40, 32'h1234_5678);
        st(2'd2, 32'h44, 32'h9ABC_DEF0);
        ld(2'd2, 1'b0, 32'h40, got);
        check_eq("b2b_first", got, 32'h1234_5678);
        ld(2'd2, 1'b0, 32'h44, got);
        check_eq("b2b_second", got, 32'h9ABC_DEF0);
        step(1'b1, 1'b0, 2'd2, 1'b0, 32'h48, 32'h0, 1'b1, got);
        check_eq("b2b_third_held", got, 32'h9ABC_DEF0);
        repeat (DEPTH) idle(1'b0);
        ld(2'd2, 1'b0, 32'h44, got);
        check_eq("clr_zero", got, 32'h0);

        // Address aliasing and illegal size
        st(2'd2, 32'h40 + MEMB, 32'hA5A5_5A5A);
        ld(2'd2, 1'b0, 32'h40, got);
        check_eq("alias", got, 32'hA5A5_5A5A);
        st(2'd3, 32'h40, 32'hFFFF_FFFF);
        check_eq("ill_err", 32'(misalign_err), 32'd1);
        ld(2'd3, 1'b0, 32'h40, got);
        check_eq("ill_rdata", got, 32'h0);
        ld(2'd2, 1'b0, 32'h40, got);
        check_eq("ill_nowrite", got, 32'hA5A5_5A5A);

        // Randomised traffic with occasional clears
        for (int n = 0; n < 400; n++) begin
            r    = $urandom_range(0, 9);
            r_sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r_v  = ($urandom_range(0, 4) != 0);
            r_w  = 1'($urandom_range(0, 1));
            r_u  = 1'($urandom_range(0, 1));
            r_c  = ($urandom_range(0, 79) == 0);
            step(r_v, r_w, r_sz, r_u, $urandom(), $urandom(), r_c, got);
        end
        repeat (DEPTH + 1) idle(1'b0);

        // Reset in the middle of a response
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        addr = 32'h40; mem_clear = 1'b0;
        @(posedge clk);
        #1;
        check_eq("pre_rst_valid", 32'(rsp_valid), 32'd1);
        do_reset();
        req_valid = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (DEPTH) idle(1'b0);
        ld(2'd2, 1'b0, 32'h40, got);
        check_eq("post_rst_zero", got, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
